// File: rtl/ajuste_tiempo_n_if.sv
// Button/enable inputs and time-value outputs of the time-setting controller.
// master = whoever drives the buttons, slave = the controller itself.
interface ajuste_tiempo_n_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic       set_time;
    logic [5:0] set_seg;
    logic [5:0] set_min;
    logic [5:0] set_hr;
    logic [1:0] field;
    logic       changed;

    modport master (
        output btn_up, btn_down, btn_sel, set_time,
        input  set_seg, set_min, set_hr, field, changed
    );

    modport slave (
        input  btn_up, btn_down, btn_sel, set_time,
        output set_seg, set_min, set_hr, field, changed
    );
endinterface

// File: rtl/ajuste_tiempo_n.sv
// Time-setting controller: turns debounced button levels into single steps and
// auto-repeat steps of sec/min/hr, with edge-triggered field select and optional carry.
module ajuste_tiempo_n #(
    parameter int unsigned HOUR_MAX      = 23,
    parameter int unsigned SEC_INIT      = 30,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter bit          CARRY_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    ajuste_tiempo_n_if.slave  bus
);

    localparam logic [25:0] HOLD_LOAD = 26'(HOLD_CYCLES - 1);
    localparam logic [25:0] REP_LOAD  = 26'(REPEAT_CYCLES - 1);
    localparam logic [5:0]  HR_LIM    = 6'(HOUR_MAX);
    localparam logic [5:0]  MS_LIM    = 6'd59;
    localparam logic [5:0]  SEC_RST   = 6'(SEC_INIT);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t      state;
    logic [25:0] cnt;
    logic        prev_up, prev_down, prev_sel;
    logic [5:0]  seg_q, min_q, hr_q;
    logic [1:0]  field_q;
    logic        stepped_q, changed_q;

    function automatic logic at_limit(input logic [5:0] v, input logic [5:0] lim, input logic up);
        return up ? (v == lim) : (v == 6'd0);
    endfunction

    function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] lim, input logic up);
        if (up) return (v == lim) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? lim : v - 6'd1;
    endfunction

    logic press_up, press_down, press_sel;
    logic up_only, down_only, dir_act, press_act, repeat_due, step;
    logic sec_step, sec_wrap, min_step, min_wrap, hr_step;

    assign press_up   = bus.btn_up   & ~prev_up;
    assign press_down = bus.btn_down & ~prev_down;
    assign press_sel  = bus.btn_sel  & ~prev_sel;

    assign up_only    = bus.btn_up & ~bus.btn_down;
    assign down_only  = bus.btn_down & ~bus.btn_up;
    assign dir_act    = up_only | down_only;
    assign press_act  = (up_only & press_up) | (down_only & press_down);
    assign repeat_due = (state != IDLE) && (cnt == '0);
    assign step       = bus.set_time & dir_act & (press_act | repeat_due);

    // Carry chain: a wrap in a lower field steps the next field on the same edge.
    assign sec_step = step && (field_q == 2'd0);
    assign sec_wrap = sec_step && at_limit(seg_q, MS_LIM, up_only);
    assign min_step = step && ((field_q == 2'd1) || (CARRY_EN && sec_wrap));
    assign min_wrap = min_step && at_limit(min_q, MS_LIM, up_only);
    assign hr_step  = step && ((field_q == 2'd2) || (CARRY_EN && min_wrap));

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments, so every branch below
        // sees pre-edge values and a later assignment to a register wins.
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prev_up   <= 1'b1;
            prev_down <= 1'b1;
            prev_sel  <= 1'b1;
            seg_q     <= SEC_RST;
            min_q     <= '0;
            hr_q      <= '0;
            field_q   <= '0;
            stepped_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            prev_up   <= bus.btn_up;
            prev_down <= bus.btn_down;
            prev_sel  <= bus.btn_sel;
            stepped_q <= step;
            changed_q <= stepped_q;

            if (sec_step) seg_q <= bump(seg_q, MS_LIM, up_only);
            if (min_step) min_q <= bump(min_q, MS_LIM, up_only);
            if (hr_step)  hr_q  <= bump(hr_q, HR_LIM, up_only);

            if (!bus.set_time || !dir_act) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (press_act) begin
                state <= HOLD;
                cnt   <= HOLD_LOAD;
            end else if (state != IDLE) begin
                if (cnt == '0) begin
                    state <= REPEAT;
                    cnt   <= REP_LOAD;
                end else begin
                    cnt <= cnt - 26'd1;
                end
            end

            // Select overrides the FSM update above; any step this edge used the old field.
            if (bus.set_time && press_sel) begin
                state   <= IDLE;
                cnt     <= '0;
                field_q <= (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
            end
        end
    end

    assign bus.set_seg = seg_q;
    assign bus.set_min = min_q;
    assign bus.set_hr  = hr_q;
    assign bus.field   = field_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_ajuste_tiempo_n.sv
// Scoreboard bench: carry and no-carry instances share stimulus; a time-based
// reference model predicts each step and a monitor checks it on every changed pulse.
module tb_ajuste_tiempo_n;

    localparam int H  = 8;
    localparam int R  = 3;
    localparam int HM = 23;
    localparam int M  = (HM + 1) * 3600;

    typedef struct {
        int s;
        int m;
        int h;
    } tv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ajuste_tiempo_n_if ifc_c ();
    ajuste_tiempo_n_if ifc_n ();

    ajuste_tiempo_n #(.HOUR_MAX(HM), .SEC_INIT(30), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CARRY_EN(1'b1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc_c));
    ajuste_tiempo_n #(.HOUR_MAX(HM), .SEC_INIT(30), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CARRY_EN(1'b0))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(ifc_n));

    int chk = 0;
    int err = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: total seconds for the carry instance, separate fields otherwise;
    // auto-repeat is described by the age of the current hold.
    int   tot = 30;
    int   ns = 30, nm = 0, nh = 0;
    int   m_field = 0;
    int   m_age = -1;
    logic mp_up = 1'b1, mp_dn = 1'b1, mp_sel = 1'b1;
    tv_t  q_c[$];
    tv_t  q_n[$];

    task automatic apply_step(input int d);
        int unit;
        unit = (m_field == 0) ? 1 : (m_field == 1) ? 60 : 3600;
        tot = (tot + d * unit + M) % M;
        q_c.push_back('{tot % 60, (tot / 60) % 60, tot / 3600});
        case (m_field)
            0:       ns = (ns + d + 60) % 60;
            1:       nm = (nm + d + 60) % 60;
            default: nh = (nh + d + HM + 1) % (HM + 1);
        endcase
        q_n.push_back('{ns, nm, nh});
    endtask

    always @(posedge clk) begin
        logic up, dn, sel, st, pu, pd, ps, stp;
        int   d;
        up = ifc_c.btn_up; dn = ifc_c.btn_down; sel = ifc_c.btn_sel; st = ifc_c.set_time;
        if (!rst_n) begin
            tot = 30; ns = 30; nm = 0; nh = 0;
            m_field = 0; m_age = -1;
            mp_up = 1'b1; mp_dn = 1'b1; mp_sel = 1'b1;
            q_c.delete();
            q_n.delete();
        end else begin
            pu = up & ~mp_up; pd = dn & ~mp_dn; ps = sel & ~mp_sel;
            stp = 1'b0;
            d = up ? 1 : -1;
            if (st) begin
                if (up != dn) begin
                    if ((up && pu) || (dn && pd)) begin
                        stp = 1'b1;
                        m_age = 0;
                    end else if (m_age >= 0) begin
                        m_age++;
                        if (m_age == H || (m_age > H && (m_age - H) % R == 0)) stp = 1'b1;
                    end
                end else begin
                    m_age = -1;
                end
                if (stp) apply_step(d);
                if (ps) begin
                    m_age = -1;
                    m_field = (m_field + 1) % 3;
                end
            end else begin
                m_age = -1;
            end
            mp_up = up; mp_dn = dn; mp_sel = sel;
        end
    end

    // Monitor: a changed pulse vouches for the values seen one cycle earlier.
    tv_t snap_c, snap_n;
    always @(negedge clk) begin
        tv_t e;
        if (mon_en) begin
            if (ifc_c.changed) begin
                check("changed_c_pending", int'(q_c.size() > 0), 1);
                if (q_c.size() > 0) begin
                    e = q_c.pop_front();
                    check("sb_c_sec", snap_c.s, e.s);
                    check("sb_c_min", snap_c.m, e.m);
                    check("sb_c_hr",  snap_c.h, e.h);
                end
            end
            if (ifc_n.changed) begin
                check("changed_n_pending", int'(q_n.size() > 0), 1);
                if (q_n.size() > 0) begin
                    e = q_n.pop_front();
                    check("sb_n_sec", snap_n.s, e.s);
                    check("sb_n_min", snap_n.m, e.m);
                    check("sb_n_hr",  snap_n.h, e.h);
                end
            end
            check("field_c", int'(ifc_c.field), m_field);
            check("field_n", int'(ifc_n.field), m_field);
            snap_c = '{int'(ifc_c.set_seg), int'(ifc_c.set_min), int'(ifc_c.set_hr)};
            snap_n = '{int'(ifc_n.set_seg), int'(ifc_n.set_min), int'(ifc_n.set_hr)};
        end
    end

    task automatic drive(input logic up, input logic dn, input logic sel, input logic st);
        ifc_c.btn_up = up; ifc_c.btn_down = dn; ifc_c.btn_sel = sel; ifc_c.set_time = st;
        ifc_n.btn_up = up; ifc_n.btn_down = dn; ifc_n.btn_sel = sel; ifc_n.set_time = st;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn);
        drive(up, dn, 1'b0, 1'b1);
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
    endtask

    task automatic chk_c(input string tag, input int s, input int m, input int h);
        check({tag, "_c_sec"}, int'(ifc_c.set_seg), s);
        check({tag, "_c_min"}, int'(ifc_c.set_min), m);
        check({tag, "_c_hr"},  int'(ifc_c.set_hr), h);
    endtask

    task automatic chk_n(input string tag, input int s, input int m, input int h);
        check({tag, "_n_sec"}, int'(ifc_n.set_seg), s);
        check({tag, "_n_min"}, int'(ifc_n.set_min), m);
        check({tag, "_n_hr"},  int'(ifc_n.set_hr), h);
    endtask

    initial begin
        int pat;
        logic up, dn, sel, st;

        // btn_up held through reset must not step after release of reset
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        mon_en = 1'b1;
        rst_n = 1'b1;
        tick(5);
        chk_c("reset", 30, 0, 0);
        check("reset_field", int'(ifc_c.field), 0);
        check("reset_changed", int'(ifc_c.changed), 0);

        // press latency: value after edge k, changed after edge k+1
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("press_value", int'(ifc_c.set_seg), 31);
        check("press_changed_early", int'(ifc_c.changed), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("press_changed", int'(ifc_c.changed), 1);
        tick(1);
        check("press_changed_once", int'(ifc_c.changed), 0);

        // down to 5, then hold down 20 cycles: steps at offsets 0,8,11,14,17
        repeat (26) pulse(1'b0, 1'b1);
        check("pre_hold_sec", int'(ifc_c.set_seg), 5);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick(20);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(10);
        chk_c("hold", 0, 0, 0);
        chk_n("hold", 0, 0, 0);

        // borrow through all fields, then carry back
        pulse(1'b0, 1'b1);
        chk_c("borrow", 59, 59, 23);
        chk_n("borrow", 59, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_c("carry", 0, 0, 0);
        chk_n("carry", 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        check("carry_changed", int'(ifc_c.changed), 1);
        tick(1);
        check("carry_changed_once", int'(ifc_c.changed), 0);

        // select and up on the same edge: step uses old field, no repeat afterwards
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1);
        check("sel_step_sec", int'(ifc_c.set_seg), 1);
        check("sel_field", int'(ifc_c.field), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(15);
        chk_c("sel_norepeat", 1, 0, 0);

        // both buttons, set_time low, and set_time rising under a held button
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick(5);
        chk_c("both", 1, 0, 0);
        check("both_changed", int'(ifc_c.changed), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick(4);
        chk_c("disabled", 1, 0, 0);
        check("disabled_field", int'(ifc_c.field), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk_c("enable_held", 1, 0, 0);

        // reset in the middle of auto-repeat on the minute field
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(2);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick(14);
        rst_n = 1'b0;
        tick(1);
        chk_c("mid_reset", 30, 0, 0);
        check("mid_reset_field", int'(ifc_c.field), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick(3);

        // randomized phase
        for (int i = 0; i < 200; i++) begin
            pat = int'($urandom_range(0, 5));
            up  = (pat == 1 || pat == 3 || pat == 4);
            dn  = (pat == 2 || pat == 3 || pat == 5);
            sel = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 9) != 0);
            drive(up, dn, sel, st);
            tick(int'($urandom_range(1, 24)));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(6);
        check("q_c_drained", q_c.size(), 0);
        check("q_n_drained", q_n.size(), 0);
        chk_c("final", tot % 60, (tot / 60) % 60, tot / 3600);
        chk_n("final", ns, nm, nh);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/ajuste_tiempo_n.md
# ajuste_tiempo_n

Parametrised time-setting controller for the countdown/clock display path. It converts debounced push-button levels into single-step and auto-repeat adjustments of seconds, minutes and hours. Field selection is edge-triggered, and seconds→minutes→hours carry/borrow is optional. It sits between the button debouncers and the timer core, which loads `set_seg`/`set_min`/`set_hr` while `set_time` is high.

## Interface

Parameters:
- `HOUR_MAX`, 23: wrap limit of the hour field (allowed 1..63).
- `SEC_INIT`, 30: reset value of `set_seg` (allowed 0..59).
- `HOLD_CYCLES`, 50_000_000: cycles a button must stay held after its press step before auto-repeat begins (allowed 2..2^26-1).
- `REPEAT_CYCLES`, 10_000_000: cycles between auto-repeat steps (allowed 1..2^26-1).
- `CARRY_EN`, 1: 1 = wrap of a lower field carries/borrows into the next field; 0 = each field wraps independently.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `btn_up`, in, 1: increment request. Level input, already synchronised and debounced.
- `btn_down`, in, 1: decrement request. Level input, already synchronised and debounced.
- `btn_sel`, in, 1: field-select request. Level input, already synchronised and debounced.
- `set_time`, in, 1: adjustment enable.
- `set_seg`, out, 6: seconds, 0..59.
- `set_min`, out, 6: minutes, 0..59.
- `set_hr`, out, 6: hours, 0..`HOUR_MAX`.
- `field`, out, 2: active field. 0 = sec, 1 = min, 2 = hr. Value 3 never occurs.
- `changed`, out, 1: one-cycle pulse, high in the cycle after any value register updates.

## Operation

- Edge detection:
  - Each button has a previous-value register, and press = level & ~prev.
  - prev registers reset to 1, so a button held through reset produces no step until it is released and pressed again.
- Field select:
  - A `btn_sel` press while `set_time`=1 advances `field` 0→1→2→0.
  - A select press also forces the repeat FSM to IDLE.
  - A step issued on the same edge applies to the field value before the change.
- Step source:
  - Exactly one of `btn_up`/`btn_down` is high: that direction is active.
  - Both high, or neither high: no step, and the FSM goes to IDLE.
- Repeat FSM states: IDLE, HOLD, REPEAT; 26-bit down-counter `cnt`.
  - IDLE: a press in the active direction issues one step, loads `cnt`=`HOLD_CYCLES`-1 and goes to HOLD.
  - HOLD: `cnt` decrements each cycle. At `cnt`=0 with the button still held: issue a step, load `cnt`=`REPEAT_CYCLES`-1, go to REPEAT.
  - REPEAT: same as HOLD, but reloads with `REPEAT_CYCLES`-1 after each step.
  - Direction released, or both buttons high, in HOLD or REPEAT → IDLE with no step.
  - Direction switched without a release (up released and down pressed on the same edge) → treated as a new press in the new direction.
- Step arithmetic, per field with limit L (59, 59 or `HOUR_MAX`):
  - Increment: L→0, otherwise +1.
  - Decrement: 0→L, otherwise −1.
- Carry/borrow (`CARRY_EN`=1):
  - A sec wrap also steps min in the same direction, on the same edge.
  - A min wrap, including one caused by a carry, also steps hr.
  - hr wraps with no further effect.
  - Example: 23:59:59 up on sec → 00:00:00 in one cycle.
  - With `CARRY_EN`=0 only the selected field changes.
- `set_time`=0:
  - No steps and no field change.
  - FSM goes to IDLE.
  - Values hold.
  - prev registers still track the buttons, so a button held while `set_time` rises does not step until it is re-pressed.

## Timing

- Reset values (after any edge with `rst_n`=0):
  - `set_seg`=`SEC_INIT`, `set_min`=0, `set_hr`=0, `field`=0, `changed`=0.
  - FSM=IDLE, `cnt`=0, prev registers=1.
- Reset asserted mid-repeat aborts the repeat immediately. Reset has priority over every other input.
- Press latency:
  - Button sampled high at edge k (low at k−1) → new value visible after edge k.
  - `changed`=1 for the cycle after edge k+1.
- Auto-repeat, button held continuously from edge k:
  - Steps occur at edges k, k+`HOLD_CYCLES`, then k+`HOLD_CYCLES`+n·`REPEAT_CYCLES` for n ≥ 1.
- Select latency: `field` changes after the edge that samples the press.
- Outputs are registered. There are no combinational input→output paths.

## Test plan

- Reset, then release: `set_seg`=30, `set_min`=0, `set_hr`=0, `field`=0, `changed`=0. `btn_up` held through reset gives no step until it is released and re-pressed.
- `set_time`=1, `field`=0, one 1-cycle `btn_up` pulse at `set_seg`=59 with `CARRY_EN`=1 → 0 sec, `set_min` +1, a single `changed` pulse. Repeat with `CARRY_EN`=0 → `set_min` unchanged.
- Run with `HOLD_CYCLES`=8 and `REPEAT_CYCLES`=3. Hold `btn_down` 20 cycles from `set_seg`=5 → steps at offsets 0, 8, 11, 14, 17 → `set_seg`=0. Release, then no further change.
- Preload 23:59:59, `field`=0, `CARRY_EN`=1, press up → 00:00:00 in one edge. Preload 00:00:00 and press down → 23:59:59.
- `btn_sel` press and `btn_up` press on the same edge at `field`=0 → `set_seg` increments, `field`=1. Holding `btn_up` then produces no repeat until it is re-pressed.
- `btn_up` and `btn_down` both high, or `set_time`=0 with presses applied → no value change and no `changed` pulse. `btn_sel` with `set_time`=0 → `field` unchanged.
